// File: rtl/uart_rx_fifo_param_if.sv
// Bus between the UART byte receiver, the receive FIFO and the write-back datapath.
// The master drives the strobes and data; the slave (the FIFO) returns the head word and status.
interface uart_rx_fifo_param_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             push;
  logic [WIDTH-1:0] data_in;
  logic             pop;
  logic             clear_flags;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, data_in, pop, clear_flags,
    input  data_out, empty, full, almost_full, count, overflow, underflow
  );

  modport slave (
    input  push, data_in, pop, clear_flags,
    output data_out, empty, full, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/uart_rx_fifo_param.sv
// Parametrised first-word-fall-through receive FIFO with occupancy, almost-full,
// sticky overflow/underflow and a selectable full-policy (drop-newest or overwrite-oldest).
module uart_rx_fifo_param #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int AF_LEVEL  = DEPTH - 1,
  parameter int OVERWRITE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_rx_fifo_param_if.slave   bus
);
  localparam int              AW      = $clog2(DEPTH);
  localparam int              CW      = AW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]   AF_C    = CW'(AF_LEVEL);
  localparam logic            OVW_C   = 1'(OVERWRITE != 0);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic             w_wr_en;
  logic             w_rd_en;
  logic             w_ovf_set;
  logic             w_unf_set;
  logic [CW-1:0]    w_count_nxt;

  // Accept/ignore decision for push and pop, flag events and next occupancy.
  always_comb begin
    w_empty     = (r_count == {CW{1'b0}});
    w_full      = (r_count == DEPTH_C);
    // When full without a pop, a push only lands under the overwrite policy, and then evicts the head.
    w_wr_en     = bus.push & (~w_full | bus.pop | OVW_C);
    w_rd_en     = (bus.pop & ~w_empty) | (bus.push & w_full & ~bus.pop & OVW_C);
    w_ovf_set   = bus.push & w_full & ~bus.pop;
    w_unf_set   = bus.pop & w_empty;
    w_count_nxt = r_count;
    if (w_wr_en && !w_rd_en) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_wr_en && w_rd_en) begin
      w_count_nxt = r_count - CW'(1);
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Storage array write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= bus.data_in;
    end
  end

  // Pointers, occupancy and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= {AW{1'b0}};
      r_rd_ptr    <= {AW{1'b0}};
      r_count     <= {CW{1'b0}};
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count     <= w_count_nxt;
      r_overflow  <= w_ovf_set | (r_overflow & ~bus.clear_flags);
      r_underflow <= w_unf_set | (r_underflow & ~bus.clear_flags);
    end
  end

  assign bus.empty       = w_empty;
  assign bus.full        = w_full;
  assign bus.almost_full = (r_count >= AF_C);
  assign bus.count       = r_count;
  assign bus.overflow    = r_overflow;
  assign bus.underflow   = r_underflow;
  assign bus.data_out    = w_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// Bench for uart_rx_fifo_param: a drop-policy and an overwrite-policy instance share one stimulus
// stream and are each compared against a queue-based reference model.
module tb_uart_rx_fifo_param;
  localparam int W = 32;
  localparam int D = 4;
  localparam int AF = D - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          clear_flags = 1'b0;
  logic [W-1:0]  data_in = '0;

  int n_checks = 0;
  int n_fail = 0;

  logic [W-1:0] mq [2][$];
  logic         m_ovf [2];
  logic         m_unf [2];

  logic [W-1:0] o_dout [2];
  logic [2:0]   o_cnt [2];
  logic         o_emp [2];
  logic         o_full [2];
  logic         o_af [2];
  logic         o_ovf [2];
  logic         o_unf [2];

  uart_rx_fifo_param_if #(.WIDTH(W), .DEPTH(D)) if_d ();
  uart_rx_fifo_param_if #(.WIDTH(W), .DEPTH(D)) if_o ();

  uart_rx_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .OVERWRITE(0)) dut_drop (
    .clk(clk), .reset(reset), .bus(if_d));
  uart_rx_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .OVERWRITE(1)) dut_ovw (
    .clk(clk), .reset(reset), .bus(if_o));

  assign if_d.push = push;   assign if_d.pop = pop;
  assign if_d.data_in = data_in; assign if_d.clear_flags = clear_flags;
  assign if_o.push = push;   assign if_o.pop = pop;
  assign if_o.data_in = data_in; assign if_o.clear_flags = clear_flags;

  assign o_dout[0] = if_d.data_out; assign o_dout[1] = if_o.data_out;
  assign o_cnt[0]  = if_d.count;    assign o_cnt[1]  = if_o.count;
  assign o_emp[0]  = if_d.empty;    assign o_emp[1]  = if_o.empty;
  assign o_full[0] = if_d.full;     assign o_full[1] = if_o.full;
  assign o_af[0]   = if_d.almost_full; assign o_af[1] = if_o.almost_full;
  assign o_ovf[0]  = if_d.overflow; assign o_ovf[1]  = if_o.overflow;
  assign o_unf[0]  = if_d.underflow; assign o_unf[1] = if_o.underflow;

  always #5 clk = ~clk;

  function automatic logic [W-1:0] exp_dout(input int k);
    return (mq[k].size() == 0) ? '0 : mq[k][0];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete(); m_ovf[k] = 1'b0; m_unf[k] = 1'b0;
    end
  endtask

  // Reference behaviour: k=0 drops on full, k=1 evicts the oldest word.
  task automatic model_edge();
    bit f, e, oset, uset;
    for (int k = 0; k < 2; k++) begin
      f = (mq[k].size() == D); e = (mq[k].size() == 0);
      oset = push && f && !pop; uset = pop && e;
      if (pop && !e) void'(mq[k].pop_front());
      if (push) begin
        if (!f || pop) mq[k].push_back(data_in);
        else if (k == 1) begin void'(mq[k].pop_front()); mq[k].push_back(data_in); end
      end
      m_ovf[k] = oset || (m_ovf[k] && !clear_flags);
      m_unf[k] = uset || (m_unf[k] && !clear_flags);
    end
  endtask

  task automatic step(input logic pu, input logic po, input logic cl, input logic [W-1:0] d);
    @(negedge clk); push = pu; pop = po; clear_flags = cl; data_in = d;
    @(posedge clk); model_edge(); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); push = 1'b0; pop = 1'b0; clear_flags = 1'b0; reset = 1'b1;
    model_clear();
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; model_clear(); #12;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (o_emp[k] !== 1'b1) begin n_fail++; $display("FAIL reset_empty dut%0d got %b want 1", k, o_emp[k]); end
      n_checks++; if (o_full[k] !== 1'b0) begin n_fail++; $display("FAIL reset_full dut%0d got %b want 0", k, o_full[k]); end
      n_checks++; if (o_af[k] !== 1'b0) begin n_fail++; $display("FAIL reset_af dut%0d got %b want 0", k, o_af[k]); end
      n_checks++; if (o_cnt[k] !== 3'd0) begin n_fail++; $display("FAIL reset_count dut%0d got %0d want 0", k, o_cnt[k]); end
      n_checks++; if (o_dout[k] !== 32'h0) begin n_fail++; $display("FAIL reset_dout dut%0d got %h want 0", k, o_dout[k]); end
      n_checks++; if ({o_ovf[k], o_unf[k]} !== 2'b00) begin n_fail++; $display("FAIL reset_flags dut%0d got %b want 00", k, {o_ovf[k], o_unf[k]}); end
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_fill_drain();
    logic [W-1:0] v;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      v = 32'hA1 + 32'(i);
      step(1'b1, 1'b0, 1'b0, v);
      for (int k = 0; k < 2; k++) begin
        n_checks++; if (o_cnt[k] !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_count dut%0d got %0d want %0d", k, o_cnt[k], i + 1); end
        n_checks++; if (o_af[k] !== (i + 1 >= AF)) begin n_fail++; $display("FAIL fill_af dut%0d got %b want %b", k, o_af[k], i + 1 >= AF); end
        n_checks++; if (o_full[k] !== (i == 3)) begin n_fail++; $display("FAIL fill_full dut%0d got %b want %b", k, o_full[k], i == 3); end
      end
    end
    for (int i = 0; i < 4; i++) begin
      v = 32'hA1 + 32'(i);
      for (int k = 0; k < 2; k++) begin
        n_checks++; if (o_dout[k] !== v) begin n_fail++; $display("FAIL drain_dout dut%0d got %h want %h", k, o_dout[k], v); end
      end
      step(1'b0, 1'b1, 1'b0, '0);
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (o_emp[k] !== 1'b1 || o_dout[k] !== 32'h0) begin n_fail++; $display("FAIL drain_empty dut%0d got empty=%b dout=%h want 1/0", k, o_emp[k], o_dout[k]); end
    end
  endtask

  task automatic test_full_policy();
    logic [W-1:0] want;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'hA1 + 32'(i));
    step(1'b1, 1'b0, 1'b0, 32'hB5);
    n_checks++; if (o_dout[0] !== 32'hA1) begin n_fail++; $display("FAIL drop_head got %h want a1", o_dout[0]); end
    n_checks++; if (o_dout[1] !== 32'hA2) begin n_fail++; $display("FAIL ovw_head got %h want a2", o_dout[1]); end
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (o_ovf[k] !== 1'b1 || o_cnt[k] !== 3'd4) begin n_fail++; $display("FAIL ovf_set dut%0d got ovf=%b cnt=%0d want 1/4", k, o_ovf[k], o_cnt[k]); end
    end
    // Set event and clear in the same cycle: the set wins.
    step(1'b1, 1'b0, 1'b1, 32'hB6);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (o_ovf[k] !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins dut%0d got %b want 1", k, o_ovf[k]); end
    end
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 2; k++) begin
        want = exp_dout(k);
        n_checks++; if (o_dout[k] !== want) begin n_fail++; $display("FAIL policy_drain dut%0d got %h want %h", k, o_dout[k], want); end
      end
      step(1'b0, 1'b1, 1'b0, '0);
    end
    step(1'b0, 1'b0, 1'b1, '0);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (o_ovf[k] !== 1'b0) begin n_fail++; $display("FAIL ovf_clear dut%0d got %b want 0", k, o_ovf[k]); end
    end
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] last;
    do_reset();
    step(1'b1, 1'b1, 1'b0, 32'h11);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (o_cnt[k] !== 3'd1 || o_dout[k] !== 32'h11 || o_unf[k] !== 1'b1) begin
        n_fail++; $display("FAIL sim_empty dut%0d got cnt=%0d dout=%h unf=%b want 1/11/1", k, o_cnt[k], o_dout[k], o_unf[k]); end
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 32'h30 + 32'(i));
    step(1'b1, 1'b1, 1'b0, 32'h22);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (o_cnt[k] !== 3'd4 || o_ovf[k] !== 1'b0) begin n_fail++; $display("FAIL sim_full dut%0d got cnt=%0d ovf=%b want 4/0", k, o_cnt[k], o_ovf[k]); end
    end
    for (int i = 0; i < 4; i++) begin
      last = o_dout[0];
      step(1'b0, 1'b1, 1'b0, '0);
    end
    n_checks++; if (last !== 32'h22) begin n_fail++; $display("FAIL sim_tail got %h want 22", last); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'(i));
      for (int k = 0; k < 2; k++) begin
        n_checks++; if (o_dout[k] !== 32'(i) || o_cnt[k] > 3'd1) begin n_fail++; $display("FAIL wrap dut%0d got dout=%h cnt=%0d want %h/<=1", k, o_dout[k], o_cnt[k], i); end
      end
      step(1'b0, 1'b1, 1'b0, '0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'hC0 + 32'(i));
    push = 1'b0; reset = 1'b1; #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (o_emp[k] !== 1'b1 || o_cnt[k] !== 3'd0) begin n_fail++; $display("FAIL mid_reset dut%0d got empty=%b cnt=%0d want 1/0", k, o_emp[k], o_cnt[k]); end
    end
    model_clear();
    @(negedge clk); reset = 1'b0;
    step(1'b1, 1'b0, 1'b0, 32'h5A);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (o_dout[k] !== 32'h5A || o_cnt[k] !== 3'd1) begin n_fail++; $display("FAIL post_reset dut%0d got dout=%h cnt=%0d want 5a/1", k, o_dout[k], o_cnt[k]); end
    end
  endtask

  task automatic test_random();
    int pct;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      pct = ((i / 100) % 2 == 0) ? 75 : 30;
      step(1'($urandom_range(0, 99) < pct), 1'($urandom_range(0, 99) >= pct),
           1'($urandom_range(0, 7) == 0), $urandom);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (o_cnt[k] !== 3'(mq[k].size()) || o_dout[k] !== exp_dout(k) ||
            o_emp[k] !== (mq[k].size() == 0) || o_full[k] !== (mq[k].size() == D) ||
            o_af[k] !== (mq[k].size() >= AF) || o_ovf[k] !== m_ovf[k] || o_unf[k] !== m_unf[k]) begin
          n_fail++;
          $display("FAIL random dut%0d cyc%0d got cnt=%0d dout=%h e=%b f=%b af=%b ovf=%b unf=%b want cnt=%0d dout=%h ovf=%b unf=%b",
                   k, i, o_cnt[k], o_dout[k], o_emp[k], o_full[k], o_af[k], o_ovf[k], o_unf[k],
                   mq[k].size(), exp_dout(k), m_ovf[k], m_unf[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_policy();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
